// File: rtl/odu_sched_pkg.sv
// Shared entry layout and scheduler state encoding for the ODU channel-ID scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package odu_sched_pkg;

  localparam int ODU_ENTRY_W = 395;

  // Entry layout: {valid, data[383:0], frame_start, row_start, mfas[7:0]}
  localparam int VALID_BIT = 394;
  localparam int DATA_MSB  = 393;
  localparam int DATA_LSB  = 10;
  localparam int FS_BIT    = 9;
  localparam int RS_BIT    = 8;
  localparam int MFAS_MSB  = 7;
  localparam int MFAS_LSB  = 0;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } sched_state_e;

endpackage

// File: rtl/odu_rr_arbiter.sv
// Rotating-priority pick: first requester strictly after i_last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_any_req low means o_grant is don't-care (driven 0).
module odu_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CHID_W = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CHID_W-1:0] i_last_grant,
  output logic [CHID_W-1:0] o_grant,
  output logic              o_any_req
);

  // Scan from the farthest candidate to the nearest so the nearest requester wins
  always_comb begin
    int                idx;
    logic [CHID_W-1:0] cand;
    o_grant   = '0;
    o_any_req = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(i_last_grant) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CHID_W'(idx);
      if (i_req[cand]) begin
        o_grant   = cand;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/odu_chid_rr_sched.sv
// Round-robin burst scheduler merging NUM_CH channel-ID FIFOs onto one tagged 384-bit ODU stream.
// Latency: out_valid two cycles after fifo_read_enable; one idle ARB cycle between bursts.
// Backpressure: none downstream; upstream throttled only by fifo_empty (stall, then abort).
// Optional: define ODU_SCHED_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module odu_chid_rr_sched
  import odu_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CHID_W    = 2,
  parameter int BURST_LEN = 8,
  parameter int STALL_MAX = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             chan_enable,
  input  logic [NUM_CH-1:0]             fifo_empty,
  input  logic [NUM_CH*ODU_ENTRY_W-1:0] fifo_data_in,
  output logic [NUM_CH-1:0]             fifo_read_enable,
  output logic [383:0]                  out_data,
  output logic                          out_valid,
  output logic                          out_frame_start,
  output logic                          out_row_start,
  output logic [7:0]                    out_mfas,
  output logic [CHID_W-1:0]             out_chid,
  output logic                          burst_abort
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX);

  sched_state_e            r_state;
  sched_state_e            w_state_nxt;
  logic [CHID_W-1:0]       r_grant;
  logic [CHID_W-1:0]       r_last_grant;
  logic [7:0]              r_word_cnt;
  logic [7:0]              r_stall_cnt;
  logic [NUM_CH-1:0]       w_eligible;
  logic [CHID_W-1:0]       w_arb_grant;
  logic                    w_any_req;
  logic                    w_rd;
  logic                    w_stall_abort;
  logic                    w_en_abort;
  logic                    r_rd_d1;
  logic [CHID_W-1:0]       r_grant_d1;
  logic [ODU_ENTRY_W-1:0]  w_entry;

  assign w_eligible = chan_enable & ~fifo_empty;

  odu_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CHID_W (CHID_W)
  ) u_arb (
    .i_req        (w_eligible),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_any_req    (w_any_req)
  );

  // Next state, read strobe and abort causes for the granted channel
  always_comb begin
    w_state_nxt      = r_state;
    w_rd             = 1'b0;
    w_stall_abort    = 1'b0;
    w_en_abort       = 1'b0;
    fifo_read_enable = '0;
    case (r_state)
      ARB: begin
        if (w_any_req) w_state_nxt = BURST;
      end
      BURST: begin
        if (!chan_enable[r_grant]) begin
          // Enable dropped: leave without reading this cycle
          w_en_abort  = 1'b1;
          w_state_nxt = ARB;
        end else if (!fifo_empty[r_grant]) begin
          w_rd                      = 1'b1;
          fifo_read_enable[r_grant] = 1'b1;
          if (r_word_cnt + 8'd1 == BURST_LAST) w_state_nxt = ARB;
        end else if (r_stall_cnt + 8'd1 == STALL_LAST) begin
          w_stall_abort = 1'b1;
          w_state_nxt   = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign burst_abort = w_stall_abort | w_en_abort;

  // State register, grant capture and burst word/stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_grant      <= '0;
      r_last_grant <= CHID_W'(NUM_CH - 1);
      r_word_cnt   <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_any_req) begin
        r_grant      <= w_arb_grant;
        r_last_grant <= w_arb_grant;
        r_word_cnt   <= '0;
        r_stall_cnt  <= '0;
      end else if (w_rd) begin
        r_word_cnt  <= r_word_cnt + 8'd1;
        r_stall_cnt <= '0;
      end else if (r_state == BURST && chan_enable[r_grant]) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
    end
  end

  // FIFO read data lands one cycle after the strobe; select it with the delayed grant
  assign w_entry = fifo_data_in[r_grant_d1*ODU_ENTRY_W +: ODU_ENTRY_W];

  // Output pipeline: payload fields only update on a valid captured entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_d1         <= 1'b0;
      r_grant_d1      <= '0;
      out_valid       <= 1'b0;
      out_chid        <= '0;
      out_data        <= '0;
      out_frame_start <= 1'b0;
      out_row_start   <= 1'b0;
      out_mfas        <= '0;
    end else begin
      r_rd_d1    <= w_rd;
      r_grant_d1 <= r_grant;
      out_chid   <= r_grant_d1;
      out_valid  <= r_rd_d1 & w_entry[VALID_BIT];
      if (r_rd_d1 & w_entry[VALID_BIT]) begin
        out_data        <= w_entry[DATA_MSB:DATA_LSB];
        out_frame_start <= w_entry[FS_BIT];
        out_row_start   <= w_entry[RS_BIT];
        out_mfas        <= w_entry[MFAS_MSB:MFAS_LSB];
      end
    end
  end

`ifdef ODU_SCHED_UNDERRUN_CNT_EN
  // Saturating count of aborts caused by the source running dry mid-burst
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (w_stall_abort && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_odu_chid_rr_sched.sv
// Scoreboard bench for odu_chid_rr_sched: FIFO models, round-robin transaction model, data monitor.
// Latency checked: out_valid/out_chid two cycles after each observed read.
// Backpressure: none; FIFOs are preloaded per phase and drained by the scheduler.
module tb_odu_chid_rr_sched;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int BL    = 8;
  localparam int SM    = 15;
  localparam int EW    = 395;
  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    chan_enable;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH*EW-1:0] fifo_data_in;
  logic [NCH-1:0]    fifo_read_enable;
  logic [383:0]      out_data;
  logic              out_valid;
  logic              out_frame_start;
  logic              out_row_start;
  logic [7:0]        out_mfas;
  logic [CW-1:0]     out_chid;
  logic              burst_abort;
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  odu_chid_rr_sched #(
    .NUM_CH    (NCH),
    .CHID_W    (CW),
    .BURST_LEN (BL),
    .STALL_MAX (SM)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .chan_enable      (chan_enable),
    .fifo_empty       (fifo_empty),
    .fifo_data_in     (fifo_data_in),
    .fifo_read_enable (fifo_read_enable),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_frame_start  (out_frame_start),
    .out_row_start    (out_row_start),
    .out_mfas         (out_mfas),
    .out_chid         (out_chid),
    .burst_abort      (burst_abort)
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt     (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-channel source FIFO contents (monotonic head/tail, never wraps in this run)
  logic [EW-1:0] mem [NCH][DEPTH];
  int            head [NCH];
  int            tail [NCH];

  // Scoreboard of expected output words
  int            exp_ch [$];
  logic [EW-1:0] exp_e  [$];

  // Observed read/abort history (cycle stamps) for timing checks
  int cyc = 0;
  int rd_cyc [$];
  int rd_ch  [$];
  int ab_cyc [$];

  // Two-deep expectation of out_valid / out_chid behind each read
  logic p1 = 1'b0, p2 = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0;
  int   c1 = 0, c2 = 0;

  // Reference model state
  int m_last     = NCH - 1;
  int m_stall_ab = 0;

  logic [EW-1:0] mon_e;
  int            mon_c;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input logic vbit);
    logic [383:0] d;
    for (int w = 0; w < 12; w++) d[w*32 +: 32] = $urandom();
    mem[ch][tail[ch]] = {vbit, d, 1'($urandom()), 1'($urandom()), 8'($urandom())};
    tail[ch]++;
    fifo_empty[ch] = 1'b0;
  endtask

  // One clock: sample and check at negedge, then model FIFO pops just after posedge
  task automatic cycle();
    logic [NCH-1:0] rd;
    logic           cur_v;
    logic           cur_s;
    int             cur_c;
    cur_v = 1'b0;
    cur_s = 1'b0;
    cur_c = 0;
    @(negedge clk);
    rd = fifo_read_enable;
    if (!rst) begin
      chk("out_valid_timing", int'(out_valid), int'(p2));
      if (s2) chk("out_chid_delay", int'(out_chid), c2);
      chk("rd_at_most_one", int'($countones(fifo_read_enable) <= 1), 1);
      if (burst_abort) ab_cyc.push_back(cyc);
      for (int i = 0; i < NCH; i++) begin
        if (fifo_read_enable[i]) begin
          chk("rd_nonempty", int'(fifo_empty[i]), 0);
          if (head[i] < tail[i]) begin
            cur_s = 1'b1;
            cur_c = i;
            cur_v = mem[i][head[i]][394];
            rd_cyc.push_back(cyc);
            rd_ch.push_back(i);
          end
        end
      end
    end
    p2 = p1; s2 = s1; c2 = c1;
    p1 = cur_v; s1 = cur_s; c1 = cur_c;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rd[i] && head[i] < tail[i]) begin
        fifo_data_in[i*EW +: EW] = mem[i][head[i]];
        head[i]++;
        fifo_empty[i] = (head[i] == tail[i]);
      end
    end
    cyc++;
  endtask

  // Transaction-level round robin over current FIFO contents with static enables
  task automatic model();
    int cnt [NCH];
    int ptr [NCH];
    int ch, n, found;
    for (int i = 0; i < NCH; i++) begin
      ptr[i] = head[i];
      cnt[i] = chan_enable[i] ? (tail[i] - head[i]) : 0;
    end
    forever begin
      found = -1;
      for (int k = 1; k <= NCH; k++) begin
        ch = (m_last + k) % NCH;
        if (found < 0 && cnt[ch] > 0) found = ch;
      end
      if (found < 0) break;
      n = (cnt[found] < BL) ? cnt[found] : BL;
      for (int j = 0; j < n; j++) begin
        if (mem[found][ptr[found] + j][394]) begin
          exp_e.push_back(mem[found][ptr[found] + j]);
          exp_ch.push_back(found);
        end
      end
      ptr[found] += n;
      cnt[found] -= n;
      if (n < BL) m_stall_ab++;
      m_last = found;
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_e.size() > 0 && w < 3000) begin
      cycle();
      w++;
    end
    chk({"drain_", name}, exp_e.size(), 0);
    repeat (SM + BL + 6) cycle();
  endtask

  // Monitor: every presented word must be the next expected one
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_cmp++;
      if (exp_e.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got chid %0d mfas %0h with nothing expected", out_chid, out_mfas);
      end else begin
        mon_e = exp_e.pop_front();
        mon_c = exp_ch.pop_front();
        if ({out_data, out_frame_start, out_row_start, out_mfas} !== mon_e[393:0] ||
            out_chid !== CW'(mon_c)) begin
          n_fail++;
          $display("FAIL word: got chid %0d data %h expected chid %0d data %h",
                   out_chid, {out_data, out_frame_start, out_row_start, out_mfas},
                   mon_c, mon_e[393:0]);
        end
      end
    end
  end

  initial begin
    int n_ab;
    int k;
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    int u0;
`endif
    chan_enable  = '1;
    fifo_empty   = '1;
    fifo_data_in = '0;
    for (int i = 0; i < NCH; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset state
    repeat (3) cycle();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data != '0), 0);
    chk("rst_out_chid", int'(out_chid), 0);
    chk("rst_abort", int'(burst_abort), 0);
    chk("rst_rd_en", int'(fifo_read_enable), 0);
    rst = 1'b0;

    // Idle: all enabled, all empty
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("idle_rd_en", int'(fifo_read_enable), 0);
      chk("idle_out_valid", int'(out_valid), 0);
    end

    // Ch1 and ch3 with 20 words each
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    for (int j = 0; j < 20; j++) begin
      push(1, 1'b1);
      push(3, 1'b1);
    end
    n_ab = m_stall_ab;
    model();
    drain("ch1_ch3");
    chk("t2_reads", rd_ch.size(), 40);
    if (rd_ch.size() == 40) begin
      chk("t2_first_ch", rd_ch[0], 1);
      chk("t2_second_ch", rd_ch[8], 3);
      chk("t2_fifth_ch", rd_ch[32], 1);
      chk("t2_sixth_ch", rd_ch[36], 3);
      chk("t2_burst_span", rd_cyc[7] - rd_cyc[0], BL - 1);
      chk("t2_burst_gap", rd_cyc[8] - rd_cyc[7], 2);
    end
    chk("t2_aborts", ab_cyc.size(), m_stall_ab - n_ab);

    // Ch0 runs dry after 3 words: stall abort
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    u0 = int'(underrun_cnt);
`endif
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    for (int j = 0; j < 3; j++) push(0, 1'b1);
    model();
    drain("ch0_stall");
    chk("t3_reads", rd_ch.size(), 3);
    chk("t3_aborts", ab_cyc.size(), 1);
    if (ab_cyc.size() == 1 && rd_cyc.size() == 3)
      chk("t3_abort_delay", ab_cyc[0] - rd_cyc[2], SM);
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    chk("t3_underrun_delta", int'(underrun_cnt) - u0, 1);
    u0 = int'(underrun_cnt);
`endif

    // Enable drop on ch2 while word 4 would be read
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    for (int j = 0; j < 10; j++) push(2, 1'b1);
    push(3, 1'b1);
    push(3, 1'b1);
    for (int j = 0; j < 3; j++) begin
      exp_e.push_back(mem[2][head[2] + j]);
      exp_ch.push_back(2);
    end
    for (int j = 0; j < 2; j++) begin
      exp_e.push_back(mem[3][head[3] + j]);
      exp_ch.push_back(3);
    end
    k = 0;
    while (rd_ch.size() < 3 && k < 100) begin
      cycle();
      k++;
    end
    chan_enable[2] = 1'b0;
    drain("ch2_drop");
    m_stall_ab++;
    m_last = 3;
    chk("t4_reads", rd_ch.size(), 5);
    if (rd_ch.size() == 5 && ab_cyc.size() >= 1) begin
      chk("t4_ch2_last", rd_ch[2], 2);
      chk("t4_next_grant", rd_ch[3], 3);
      chk("t4_abort_at_drop", ab_cyc[0] - rd_cyc[2], 1);
    end
    chk("t4_aborts", ab_cyc.size(), 2);
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    chk("t4_underrun_delta", int'(underrun_cnt) - u0, 1);
`endif

    // Ch0 entries with cleared valid bit: slot stays low, chid still moves
    chk("t5_chid_before", int'(out_chid), 3);
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    push(0, 1'b0);
    push(0, 1'b1);
    push(0, 1'b0);
    model();
    drain("ch0_invalid");
    chk("t5_reads", rd_ch.size(), 3);
    chk("t5_chid_after", int'(out_chid), 0);

    // Reset mid-burst with words in flight
    for (int j = 0; j < 8; j++) push(1, 1'b1);
    push(0, 1'b1); push(0, 1'b1);
    push(3, 1'b1); push(3, 1'b1);
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    model();
    k = 0;
    while (rd_ch.size() < 2 && k < 100) begin
      cycle();
      k++;
    end
    chk("t6_pre_reads", rd_ch.size(), 2);
    rst = 1'b1;
    cycle();
    cycle();
    exp_e.delete(); exp_ch.delete();
    p1 = 1'b0; p2 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_out_data", int'(out_data != '0), 0);
    chk("t6_out_fs_rs", int'({out_frame_start, out_row_start}), 0);
    chk("t6_out_mfas", int'(out_mfas), 0);
    chk("t6_out_chid", int'(out_chid), 0);
    chk("t6_rd_en", int'(fifo_read_enable), 0);
    chk("t6_abort", int'(burst_abort), 0);
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    chk("t6_underrun", int'(underrun_cnt), 0);
`endif
    rst = 1'b0;
    m_last = NCH - 1;
    m_stall_ab = 0;
    rd_cyc.delete(); rd_ch.delete(); ab_cyc.delete();
    model();
    drain("post_reset");
    if (rd_ch.size() > 0) chk("t6_first_grant", rd_ch[0], 0);
    else chk("t6_any_read", rd_ch.size(), 1);

    // Randomized phases: random enables, random fills, random valid bits
    for (int ph = 0; ph < 8; ph++) begin
      chan_enable = 4'($urandom());
      for (int i = 0; i < NCH; i++) begin
        k = $urandom_range(0, 20);
        for (int j = 0; j < k; j++) push(i, 1'($urandom_range(0, 7) != 0));
      end
      ab_cyc.delete();
      n_ab = m_stall_ab;
      model();
      drain("random");
      chk("rand_aborts", ab_cyc.size(), m_stall_ab - n_ab);
    end
`ifdef ODU_SCHED_UNDERRUN_CNT_EN
    chk("underrun_total", int'(underrun_cnt), m_stall_ab);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
